// File: rtl/sys_csr_trap_pkg.sv
// Shared constants for the machine-mode CSR / trap unit: CSR addresses,
// cause codes, status/enable bit positions, funct3 encodings and FSM states.
package sys_csr_trap_pkg;

  localparam logic [6:0]  OP_SYSTEM      = 7'h73;
  localparam logic [6:0]  OP_MISC_MEM    = 7'h0F;
  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET     = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_CYCLE      = 12'hC00;
  localparam logic [11:0] CSR_TIME       = 12'hC01;
  localparam logic [11:0] CSR_INSTRET    = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
  localparam logic [11:0] CSR_TIMEH      = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH   = 12'hC82;
  localparam logic [11:0] CSR_MTIMECMP   = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH  = 12'h7C1;

  localparam logic [4:0]  CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0]  CAUSE_BREAK    = 5'd3;
  localparam logic [4:0]  CAUSE_ECALL    = 5'd11;
  localparam logic [4:0]  IRQ_MSI        = 5'd3;
  localparam logic [4:0]  IRQ_MTI        = 5'd7;
  localparam logic [4:0]  IRQ_MEI        = 5'd11;

  localparam int          MSTATUS_MIE    = 3;
  localparam int          MSTATUS_MPIE   = 7;
  localparam int          MIE_MSIE       = 3;
  localparam int          MIE_MTIE       = 7;
  localparam int          MIE_MEIE       = 11;
  localparam logic [31:0] MIE_MASK       = 32'h0000_0888;

  localparam logic [2:0]  F3_CSRRW       = 3'b001;
  localparam logic [2:0]  F3_CSRRS       = 3'b010;
  localparam logic [2:0]  F3_CSRRC       = 3'b011;
  localparam logic [2:0]  F3_CSRRWI      = 3'b101;
  localparam logic [2:0]  F3_CSRRSI      = 3'b110;
  localparam logic [2:0]  F3_CSRRCI      = 3'b111;

  typedef enum logic {ST_IDLE, ST_TRAP_ENTRY} trap_state_e;

  // User counter aliases, mhartid and mip can be read but never written.
  function automatic logic csr_read_only(input logic [11:0] addr);
    return (addr[11:8] == 4'hC) || (addr == CSR_MHARTID) || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/sys_csr_timer.sv
// Machine timer: prescaler, 64-bit mtime, 64-bit mtimecmp and the MTIP compare.
module sys_csr_timer #(
  parameter int TIME_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  logic [15:0] presc;

  // Prescaler counts 0..TIME_DIV-1; mtime advances on each wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (presc == 16'(TIME_DIV - 1)) begin
      presc <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Compare register, written one 32-bit half at a time; all ones keeps MTIP low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else if (cmp_lo_we) begin
      mtimecmp <= {mtimecmp[63:32], wdata};
    end else if (cmp_hi_we) begin
      mtimecmp <= {wdata, mtimecmp[31:0]};
    end
  end

  assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/sys_csr_trap.sv
// Machine-mode CSR file with trap entry/return, counters, timer and
// interrupt arbitration; redirects the front end through jump_vld/jump_pc.
// Handshake: an instruction is consumed in any cycle where vld=1 and the
// unit is in ST_IDLE; there is no back-pressure, and vld is ignored during
// the single ST_TRAP_ENTRY cycle that follows a taken trap.
module sys_csr_trap
  import sys_csr_trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int HART_ID     = 0,
  parameter int TIME_DIV    = 100,
  parameter int RETIRE_W    = 3,
  parameter int VECTORED_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     instr,
  input  logic [XLEN-1:0]     pc,
  input  logic                vld,
  input  logic [XLEN-1:0]     rs0_word,
  input  logic [RETIRE_W-1:0] retire_cnt,
  input  logic                irq_ext,
  input  logic                irq_soft,
  output logic                jump_vld,
  output logic [XLEN-1:0]     jump_pc,
  output logic [XLEN-1:0]     csr_data,
  output logic                trap_taken,
  output trap_state_e         dbg_state
);

  trap_state_e state, next_state;
  logic        mstatus_mie, mstatus_mpie, mtvec_mode, mtip;
  logic [29:0] mtvec_base, mepc_q;
  logic [31:0] mie_en, mscratch, mcause, mtval, csr_rdata, csr_src, csr_wdata;
  logic [31:0] trap_cause, trap_tval, jump_pc_c, mip_vec, pend, tvec_base;
  logic [63:0] mcycle, minstret, mtime, mtimecmp;
  logic        csr_known, illegal, wr_attempt, irq_any, take_trap, do_mret;
  logic        csr_we, jump_vld_c;
  logic [4:0]  irq_code;

  wire [2:0]  funct3   = instr[14:12];
  wire [4:0]  rs1_idx  = instr[19:15];
  wire [11:0] csr_addr = instr[31:20];
  wire        is_csr   = (instr[6:0] == OP_SYSTEM) && (funct3 != 3'b000) && (funct3 != 3'b100);
  wire        is_fencei = (instr[6:0] == OP_MISC_MEM) && (funct3 == 3'b001);

  assign wr_attempt = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
  assign csr_src    = funct3[2] ? {27'b0, rs1_idx} : rs0_word;
  assign illegal    = is_csr && (!csr_known || (wr_attempt && csr_read_only(csr_addr)));
  assign mip_vec    = {20'b0, irq_ext, 3'b0, mtip, 3'b0, irq_soft, 3'b0};
  assign pend       = mie_en & mip_vec;
  assign irq_any    = mstatus_mie && (pend != 32'b0);
  assign irq_code   = pend[MIE_MEIE] ? IRQ_MEI : (pend[MIE_MSIE] ? IRQ_MSI : IRQ_MTI);
  assign tvec_base  = {mtvec_base, 2'b00};

  sys_csr_timer #(.TIME_DIV(TIME_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .cmp_lo_we(csr_we && (csr_addr == CSR_MTIMECMP)),
    .cmp_hi_we(csr_we && (csr_addr == CSR_MTIMECMPH)),
    .wdata    (csr_wdata),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  // CSR read mux: pre-write value of the addressed register.
  always_comb begin
    csr_rdata = '0;
    csr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:               csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MIE:                   csr_rdata = mie_en;
      CSR_MIP:                   csr_rdata = mip_vec;
      CSR_MTVEC:                 csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
      CSR_MSCRATCH:              csr_rdata = mscratch;
      CSR_MEPC:                  csr_rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:                csr_rdata = mcause;
      CSR_MTVAL:                 csr_rdata = mtval;
      CSR_MHARTID:               csr_rdata = 32'(HART_ID);
      CSR_MCYCLE, CSR_CYCLE:     csr_rdata = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: csr_rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
      CSR_TIME:                  csr_rdata = mtime[31:0];
      CSR_TIMEH:                 csr_rdata = mtime[63:32];
      CSR_MTIMECMP:              csr_rdata = mtimecmp[31:0];
      CSR_MTIMECMPH:             csr_rdata = mtimecmp[63:32];
      default:                   csr_known = 1'b0;
    endcase
  end

  // Read-modify-write data for RW/RS/RC and their immediate forms.
  always_comb begin
    csr_wdata = csr_src;
    case (funct3)
      F3_CSRRS, F3_CSRRSI: csr_wdata = csr_rdata | csr_src;
      F3_CSRRC, F3_CSRRCI: csr_wdata = csr_rdata & ~csr_src;
      default:             csr_wdata = csr_src;
    endcase
  end

  // Decode FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Decode: interrupts preempt, then exceptions, mret, fence.i, CSR writes.
  always_comb begin
    next_state = state;
    jump_vld_c = 1'b0;
    jump_pc_c  = '0;
    take_trap  = 1'b0;
    trap_cause = '0;
    trap_tval  = '0;
    do_mret    = 1'b0;
    csr_we     = 1'b0;
    if (state == ST_TRAP_ENTRY) begin
      next_state = ST_IDLE;
    end else if (vld) begin
      if (irq_any) begin
        take_trap  = 1'b1;
        trap_cause = {1'b1, 26'b0, irq_code};
        jump_pc_c  = mtvec_mode ? tvec_base + {25'b0, irq_code, 2'b00} : tvec_base;
      end else if (instr == INSTR_ECALL) begin
        take_trap  = 1'b1;
        trap_cause = {27'b0, CAUSE_ECALL};
        jump_pc_c  = tvec_base;
      end else if (instr == INSTR_EBREAK) begin
        take_trap  = 1'b1;
        trap_cause = {27'b0, CAUSE_BREAK};
        jump_pc_c  = tvec_base;
      end else if (illegal) begin
        take_trap  = 1'b1;
        trap_cause = {27'b0, CAUSE_ILLEGAL};
        trap_tval  = instr;
        jump_pc_c  = tvec_base;
      end else if (instr == INSTR_MRET) begin
        do_mret    = 1'b1;
        jump_vld_c = 1'b1;
        jump_pc_c  = {mepc_q, 2'b00};
      end else if (is_fencei) begin
        jump_vld_c = 1'b1;
        jump_pc_c  = pc + 32'd4;
      end else if (is_csr && wr_attempt) begin
        csr_we     = 1'b1;
      end
      if (take_trap) begin
        jump_vld_c = 1'b1;
        next_state = ST_TRAP_ENTRY;
      end
    end
  end

  // Trap state and software-visible registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_en       <= '0;
      mtvec_base   <= '0;
      mtvec_mode   <= 1'b0;
      mscratch     <= '0;
      mepc_q       <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else if (take_trap) begin
      mepc_q       <= pc[31:2];
      mcause       <= trap_cause;
      mtval        <= trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (do_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_wdata[MSTATUS_MIE];
          mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_en   <= csr_wdata & MIE_MASK;
        CSR_MTVEC: begin
          mtvec_base <= csr_wdata[31:2];
          mtvec_mode <= (VECTORED_EN != 0) ? csr_wdata[0] : 1'b0;
        end
        CSR_MSCRATCH: mscratch <= csr_wdata;
        CSR_MEPC:     mepc_q   <= csr_wdata[31:2];
        CSR_MCAUSE:   mcause   <= csr_wdata;
        CSR_MTVAL:    mtval    <= csr_wdata;
        default:      ;
      endcase
    end
  end

  // 64-bit counters; a write to either half replaces that half and skips the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_we && csr_addr == CSR_MCYCLE)       mcycle <= {mcycle[63:32], csr_wdata};
      else if (csr_we && csr_addr == CSR_MCYCLEH) mcycle <= {csr_wdata, mcycle[31:0]};
      else                                        mcycle <= mcycle + 64'd1;
      if (csr_we && csr_addr == CSR_MINSTRET)       minstret <= {minstret[63:32], csr_wdata};
      else if (csr_we && csr_addr == CSR_MINSTRETH) minstret <= {csr_wdata, minstret[31:0]};
      else                                          minstret <= minstret + 64'(retire_cnt);
    end
  end

  assign jump_vld   = rst && jump_vld_c;
  assign jump_pc    = rst ? jump_pc_c : '0;
  assign csr_data   = (rst && is_csr) ? csr_rdata : '0;
  assign trap_taken = (state == ST_TRAP_ENTRY);
  assign dbg_state  = state;

endmodule

// File: tb/tb_sys_csr_trap.sv
// Self-checking bench for sys_csr_trap: reset/read-back, random CSR ops on
// mscratch, timer interrupt, interrupt priority, exceptions, counters and
// asynchronous reset during trap entry.
module tb_sys_csr_trap;
  import sys_csr_trap_pkg::*;

  localparam int TB_TIME_DIV = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] FENCEI = 32'h0000_100F;

  logic        clk, rst, vld, irq_ext, irq_soft;
  logic [31:0] instr, pc, rs0_word;
  logic [2:0]  retire_cnt;
  logic        jump_vld, trap_taken;
  logic [31:0] jump_pc, csr_data;
  trap_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  int edges;
  logic        s_jump_vld;
  logic [31:0] s_jump_pc, s_csr_data;
  int          s_edges;

  sys_csr_trap #(.XLEN(32), .HART_ID(0), .TIME_DIV(TB_TIME_DIV), .RETIRE_W(3), .VECTORED_EN(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .vld(vld), .rs0_word(rs0_word),
    .retire_cnt(retire_cnt), .irq_ext(irq_ext), .irq_soft(irq_soft),
    .jump_vld(jump_vld), .jump_pc(jump_pc), .csr_data(csr_data),
    .trap_taken(trap_taken), .dbg_state(dbg_state)
  );

  // Clock and reset-relative edge count (mcycle and mtime are defined from it).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1);
    return {a, rs1, f3, 5'd1, 7'h73};
  endfunction

  // One instruction for one cycle; outputs sampled on the falling edge.
  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
    instr = i; pc = p; rs0_word = r; vld = 1'b1;
    @(negedge clk);
    s_jump_vld = jump_vld; s_jump_pc = jump_pc; s_csr_data = csr_data; s_edges = edges;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    step(csr_op(F3_CSRRS, a, 5'd0), 32'h0, 32'h0);
    d = s_csr_data;
  endtask

  task automatic idle_trap_cycle(input string name, input logic exp);
    @(negedge clk);
    checks++;
    if (trap_taken !== exp) begin failures++; $display("FAIL %s trap_taken got=%0b exp=%0b", name, trap_taken, exp); end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; vld = 1'b0; instr = '0; pc = '0; rs0_word = '0;
    retire_cnt = '0; irq_ext = 1'b0; irq_soft = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; retire_cnt = '0; irq_ext = 1'b0; irq_soft = 1'b0;
    vld = 1'b1; instr = FENCEI; pc = 32'h40; rs0_word = '0;
    #12;
    checks++; if (jump_vld !== 1'b0 || jump_pc !== 32'h0) begin failures++; $display("FAIL reset_jump got=%0b/%h exp=0/0", jump_vld, jump_pc); end
    checks++; if (trap_taken !== 1'b0) begin failures++; $display("FAIL reset_trap_taken got=%0b exp=0", trap_taken); end
    instr = csr_op(F3_CSRRS, CSR_MSTATUS, 5'd0); #1;
    checks++; if (csr_data !== 32'h0) begin failures++; $display("FAIL reset_csr_data got=%h exp=0", csr_data); end
    vld = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    read_csr(CSR_MSTATUS, d);
    checks++; if (d !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=00001800", d); end
    read_csr(CSR_MTIMECMP, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_mtimecmp got=%h exp=ffffffff", d); end
    read_csr(CSR_MHARTID, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mhartid got=%h exp=0", d); end
    read_csr(CSR_MCYCLE, d);
    checks++; if (d !== 32'(s_edges)) begin failures++; $display("FAIL reset_mcycle got=%h exp=%h", d, 32'(s_edges)); end
  endtask

  task automatic test_readback();
    logic [31:0] d, m_scratch, src, data;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [2:0]  f3_tab [6];
    f3_tab = '{F3_CSRRW, F3_CSRRS, F3_CSRRC, F3_CSRRWI, F3_CSRRSI, F3_CSRRCI};
    step(csr_op(F3_CSRRW, CSR_MSCRATCH, 5'd7), 32'h0, 32'hDEAD_BEEF);
    read_csr(CSR_MSCRATCH, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mscratch_rw got=%h exp=deadbeef", d); end
    step(csr_op(F3_CSRRS, CSR_MSCRATCH, 5'd0), 32'h0, 32'hFFFF_FFFF);
    step(csr_op(F3_CSRRC, CSR_MSCRATCH, 5'd0), 32'h0, 32'hFFFF_FFFF);
    read_csr(CSR_MSCRATCH, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mscratch_x0_nowrite got=%h exp=deadbeef", d); end
    m_scratch = 32'hDEAD_BEEF;
    for (int k = 0; k < 12; k++) begin
      f3   = f3_tab[$urandom_range(0, 5)];
      rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      data = $urandom;
      step(csr_op(f3, CSR_MSCRATCH, rs1), 32'h0, data);
      checks++;
      if (s_csr_data !== m_scratch) begin failures++; $display("FAIL mscratch_rand[%0d] f3=%0d got=%h exp=%h", k, f3, s_csr_data, m_scratch); end
      src = f3[2] ? {27'b0, rs1} : data;
      if (f3[1:0] == 2'b01) m_scratch = src;
      else if (f3[1:0] == 2'b10 && rs1 != 5'd0) m_scratch = m_scratch | src;
      else if (f3[1:0] == 2'b11 && rs1 != 5'd0) m_scratch = m_scratch & ~src;
    end
    read_csr(CSR_MSCRATCH, d);
    checks++; if (d !== m_scratch) begin failures++; $display("FAIL mscratch_final got=%h exp=%h", d, m_scratch); end
  endtask

  task automatic test_timer();
    logic [31:0] d, p, trap_pc;
    logic exp, fired;
    do_reset();
    step(csr_op(F3_CSRRW, CSR_MTVEC, 5'd1), 32'h0, 32'h0000_0101);
    step(csr_op(F3_CSRRW, CSR_MIE, 5'd1), 32'h0, 32'h0000_0080);
    step(csr_op(F3_CSRRW, CSR_MTIMECMP, 5'd1), 32'h0, 32'h3);
    step(csr_op(F3_CSRRW, CSR_MTIMECMPH, 5'd1), 32'h0, 32'h0);
    read_csr(CSR_TIME, d);
    checks++; if (d !== 32'(s_edges / TB_TIME_DIV)) begin failures++; $display("FAIL time_read got=%h exp=%h", d, 32'(s_edges / TB_TIME_DIV)); end
    step(csr_op(F3_CSRRSI, CSR_MSTATUS, 5'd8), 32'h0, 32'h0);
    fired = 1'b0; trap_pc = '0;
    for (int i = 0; i < 40 && !fired; i++) begin
      p = 32'h1000 + 32'(4 * i);
      step(NOP, p, 32'h0);
      exp = (s_edges / TB_TIME_DIV) >= 3;
      checks++;
      if (s_jump_vld !== exp) begin failures++; $display("FAIL timer_irq_edge[%0d] jump_vld got=%0b exp=%0b", i, s_jump_vld, exp); end
      if (s_jump_vld || exp) begin
        fired = 1'b1; trap_pc = p;
        checks++;
        if (s_jump_pc !== 32'h0000_011C) begin failures++; $display("FAIL timer_vector got=%h exp=0000011c", s_jump_pc); end
      end
    end
    checks++; if (!fired) begin failures++; $display("FAIL timer_irq_timeout got=none exp=interrupt"); end
    idle_trap_cycle("timer_trap_taken", 1'b1);
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_0007) begin failures++; $display("FAIL timer_mcause got=%h exp=80000007", d); end
    read_csr(CSR_MEPC, d);
    checks++; if (d !== trap_pc) begin failures++; $display("FAIL timer_mepc got=%h exp=%h", d, trap_pc); end
    read_csr(CSR_MTVAL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL timer_mtval got=%h exp=0", d); end
    read_csr(CSR_MSTATUS, d);
    checks++; if (d !== 32'h0000_1880) begin failures++; $display("FAIL timer_mstatus got=%h exp=00001880", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    irq_ext = 1'b1; irq_soft = 1'b1;
    step(csr_op(F3_CSRRW, CSR_MIE, 5'd1), 32'h0, 32'h0000_0888);
    step(csr_op(F3_CSRRSI, CSR_MSTATUS, 5'd8), 32'h0, 32'h0);
    checks++; if (s_jump_vld !== 1'b0) begin failures++; $display("FAIL prio_enable_nojump got=%0b exp=0", s_jump_vld); end
    step(NOP, 32'h300, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h0000_012C) begin failures++; $display("FAIL prio_mei_jump got=%0b/%h exp=1/0000012c", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("prio_mei_trap_taken", 1'b1);
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_000B) begin failures++; $display("FAIL prio_mei_mcause got=%h exp=8000000b", d); end
    read_csr(CSR_MIP, d);
    checks++; if (d !== 32'h0000_0888) begin failures++; $display("FAIL prio_mip got=%h exp=00000888", d); end
    irq_ext = 1'b0;
    step(INSTR_MRET, 32'h500, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h300) begin failures++; $display("FAIL prio_mret got=%0b/%h exp=1/00000300", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("prio_mret_no_trap", 1'b0);
    step(NOP, 32'h304, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h0000_010C) begin failures++; $display("FAIL prio_msi_jump got=%0b/%h exp=1/0000010c", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("prio_msi_trap_taken", 1'b1);
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_0003) begin failures++; $display("FAIL prio_msi_mcause got=%h exp=80000003", d); end
    read_csr(CSR_MEPC, d);
    checks++; if (d !== 32'h304) begin failures++; $display("FAIL prio_msi_mepc got=%h exp=00000304", d); end
    irq_soft = 1'b0;
  endtask

  task automatic test_exceptions();
    logic [31:0] d, bad;
    do_reset();
    step(csr_op(F3_CSRRW, CSR_MTVEC, 5'd1), 32'h0, 32'h0000_0080);
    step(INSTR_ECALL, 32'h200, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h80) begin failures++; $display("FAIL ecall_jump got=%0b/%h exp=1/00000080", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("ecall_trap_taken", 1'b1);
    read_csr(CSR_MEPC, d);
    checks++; if (d !== 32'h200) begin failures++; $display("FAIL ecall_mepc got=%h exp=00000200", d); end
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'd11) begin failures++; $display("FAIL ecall_mcause got=%h exp=0000000b", d); end
    step(INSTR_EBREAK, 32'h204, 32'h0);
    idle_trap_cycle("ebreak_trap_taken", 1'b1);
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL ebreak_mcause got=%h exp=00000003", d); end
    bad = csr_op(F3_CSRRW, CSR_CYCLE, 5'd5);
    bad[11:7] = 5'd0;
    step(bad, 32'h208, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h80) begin failures++; $display("FAIL illegal_jump got=%0b/%h exp=1/00000080", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("illegal_trap_taken", 1'b1);
    read_csr(CSR_MCAUSE, d);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL illegal_mcause got=%h exp=00000002", d); end
    read_csr(CSR_MTVAL, d);
    checks++; if (d !== bad) begin failures++; $display("FAIL illegal_mtval got=%h exp=%h", d, bad); end
    read_csr(CSR_MCYCLE, d);
    checks++; if (d !== 32'(s_edges)) begin failures++; $display("FAIL illegal_mcycle_unwritten got=%h exp=%h", d, 32'(s_edges)); end
    step(csr_op(F3_CSRRS, 12'h7FF, 5'd0), 32'h20C, 32'h0);
    checks++; if (s_jump_vld !== 1'b1) begin failures++; $display("FAIL unknown_csr_jump got=%0b exp=1", s_jump_vld); end
    idle_trap_cycle("unknown_trap_taken", 1'b1);
    step(FENCEI, 32'h400, 32'h0);
    checks++; if (s_jump_vld !== 1'b1 || s_jump_pc !== 32'h404) begin failures++; $display("FAIL fencei_jump got=%0b/%h exp=1/00000404", s_jump_vld, s_jump_pc); end
    idle_trap_cycle("fencei_no_trap", 1'b0);
    step(csr_op(F3_CSRRW, CSR_MTVEC, 5'd1), 32'h0, 32'h0000_0103);
    read_csr(CSR_MTVEC, d);
    checks++; if (d !== 32'h0000_0101) begin failures++; $display("FAIL mtvec_mode_bit1 got=%h exp=00000101", d); end
  endtask

  task automatic test_counters();
    logic [31:0] a, b, x, y;
    int sum;
    step(csr_op(F3_CSRRW, CSR_MCYCLE, 5'd1), 32'h0, 32'hFFFF_FFFF);
    read_csr(CSR_MCYCLE, a);
    checks++; if (a !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcycle_preload got=%h exp=ffffffff", a); end
    read_csr(CSR_MCYCLEH, a);
    checks++; if (a !== 32'h1) begin failures++; $display("FAIL mcycleh_carry got=%h exp=00000001", a); end
    read_csr(CSR_MCYCLE, a);
    checks++; if (a !== 32'h1) begin failures++; $display("FAIL mcycle_wrapped got=%h exp=00000001", a); end
    read_csr(CSR_MINSTRET, a);
    retire_cnt = 3'd3;
    repeat (5) begin @(posedge clk); #1; end
    retire_cnt = 3'd0;
    read_csr(CSR_MINSTRET, b);
    checks++; if (b !== a + 32'd15) begin failures++; $display("FAIL minstret_plus15 got=%h exp=%h", b, a + 32'd15); end
    sum = 0;
    for (int k = 0; k < 6; k++) begin
      retire_cnt = 3'($urandom_range(0, 7));
      sum += int'(retire_cnt);
      @(posedge clk); #1;
    end
    retire_cnt = 3'd0;
    read_csr(CSR_MINSTRET, a);
    checks++; if (a !== b + 32'(sum)) begin failures++; $display("FAIL minstret_random got=%h exp=%h", a, b + 32'(sum)); end
    x = $urandom;
    retire_cnt = 3'd5;
    step(csr_op(F3_CSRRW, CSR_MINSTRET, 5'd1), 32'h0, x);
    retire_cnt = 3'd0;
    read_csr(CSR_MINSTRET, a);
    checks++; if (a !== x) begin failures++; $display("FAIL minstret_write_wins got=%h exp=%h", a, x); end
    y = $urandom;
    step(csr_op(F3_CSRRW, CSR_MINSTRETH, 5'd1), 32'h0, y);
    read_csr(CSR_INSTRETH, a);
    checks++; if (a !== y) begin failures++; $display("FAIL minstreth_write got=%h exp=%h", a, y); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    step(INSTR_ECALL, 32'h600, 32'h0);
    vld = 1'b1; instr = FENCEI; pc = 32'h700;
    #2;
    checks++; if (trap_taken !== 1'b1) begin failures++; $display("FAIL areset_pre_trap got=%0b exp=1", trap_taken); end
    rst = 1'b0; #1;
    checks++; if (trap_taken !== 1'b0) begin failures++; $display("FAIL areset_trap_taken got=%0b exp=0", trap_taken); end
    checks++; if (jump_vld !== 1'b0 || jump_pc !== 32'h0) begin failures++; $display("FAIL areset_jump got=%0b/%h exp=0/0", jump_vld, jump_pc); end
    instr = csr_op(F3_CSRRS, CSR_MSTATUS, 5'd0); #1;
    checks++; if (csr_data !== 32'h0) begin failures++; $display("FAIL areset_csr_data got=%h exp=0", csr_data); end
    vld = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    read_csr(CSR_MTIMECMP, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL areset_mtimecmp got=%h exp=ffffffff", d); end
    read_csr(CSR_MTIMECMPH, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL areset_mtimecmph got=%h exp=ffffffff", d); end
    repeat (3) begin @(posedge clk); #1; end
    read_csr(CSR_TIME, d);
    checks++; if (d !== 32'(s_edges / TB_TIME_DIV)) begin failures++; $display("FAIL areset_time got=%h exp=%h", d, 32'(s_edges / TB_TIME_DIV)); end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_timer();
    test_priority();
    test_exceptions();
    test_counters();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
